io_input_ctrl: RTL and testbench
================================

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameter: TICK_DIV, 1000000, clk cycles per debounce sample tick (range 2..2^24).
REQ-002 clk  input  1  board clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ce  input  1  bus access enable from the processor IO port.
REQ-005 we  input  1  write strobe, qualified by ce.
REQ-006 addr  input  32  byte address; only addr[4:2] decoded.
REQ-007 data_i  input  32  write data.
REQ-008 data_o  output  32  read data.
REQ-009 sw  input  16  raw slide switches, asynchronous.
REQ-010 btn  input  4  raw push buttons, asynchronous, active-high.
REQ-011 irq  output  1  event interrupt; present only with IO_IN_IRQ_EN.

Function
REQ-012 Each sw/btn bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 and wrap; tick asserts for one cycle when the count equals TICK_DIV-1.
REQ-014 On each tick, every bit SHALL shift its synchronized value into a 3-deep sample history.
REQ-015 A debounced bit SHALL update on the tick where all 3 history samples agree and differ from it; otherwise it holds.
REQ-016 Worst-case latency from raw change to debounced change SHALL be 2 clk + 3 ticks; glitches shorter than 2 ticks SHALL never propagate.
REQ-017 Register map (addr[4:2]): 0 SW_STATE[15:0] RO; 1 BTN_STATE[3:0] RO; 2 BTN_EVENT[3:0] W1C; 3 EVT_COUNT[15:0], any write clears; 4 IRQ_MASK[3:0] RW (macro only).
REQ-018 Unused data_o bits SHALL read 0; undecoded offsets SHALL read 0 and ignore writes.
REQ-019 data_o SHALL be combinational from ce and addr: valid in the same cycle when ce=1, and 0 when ce=0.
REQ-020 Writes SHALL take effect on the clk edge where ce=1 and we=1.
REQ-021 BTN_EVENT[i] SHALL set on the edge where debounced btn[i] goes 0->1, and hold until cleared.
REQ-022 Release edges (1->0) SHALL NOT set events.
REQ-023 If a W1C clear and a new rising edge hit the same bit on the same edge, the set SHALL win.
REQ-024 EVT_COUNT SHALL add the number of buttons rising on that edge (0..4), saturating at 0xFFFF.
REQ-025 A clear of EVT_COUNT coincident with new rises SHALL load the number of new rises.

Reset
REQ-026 While rst=0, the following SHALL be 0: synchronizers, prescaler, histories, debounced state, BTN_EVENT, EVT_COUNT, IRQ_MASK, irq.
REQ-027 Reset SHALL take effect immediately, including mid-debounce; after release, the prescaler SHALL restart from 0.
REQ-028 An input held high through reset release SHALL debounce to 1 and count as a rising event.

Configuration
REQ-029 Macro IO_IN_IRQ_EN defined: IRQ_MASK exists at offset 4, and irq SHALL be the registered OR of (BTN_EVENT & IRQ_MASK), one clk after the event or mask change.
REQ-030 Macro undefined: no irq port, offset 4 reads 0 and ignores writes; all other behaviour is identical.

Verification (TICK_DIV=4)
REQ-031 btn=0001 held 20 clk -> BTN_STATE=0x1 within 2+12 clk; BTN_EVENT=0x1; EVT_COUNT=1.
REQ-032 sw bit 3 pulsed high for 5 clk -> SW_STATE stays 0x0000 and no event occurs.
REQ-033 btn=1111 rising together -> EVT_COUNT +4; with count preset near max (0xFFFE) -> saturates at 0xFFFF.
REQ-034 Write BTN_EVENT data_i=0x1 on the same edge as btn[0] debounces high -> BTN_EVENT[0]=1; write 0x1 later -> reads 0.
REQ-035 rst=0 asserted mid-debounce with sw=0xA5A5 -> all reads 0 immediately; after release, SW_STATE=0xA5A5 after 2+12 clk.
REQ-036 IO_IN_IRQ_EN: IRQ_MASK=0x2, btn[1] pressed -> irq=1 one clk after the event; W1C write 0x2 -> irq=0 next clk.

Source files
------------

// File: rtl/io_input_ctrl.sv
// Debounced switch/button input block with a small memory-mapped register file.
// Optional IRQ_MASK register and irq output are enabled by defining IO_IN_IRQ_EN.
module io_input_ctrl #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [15:0] sw,
  input  logic [3:0]  btn
`ifdef IO_IN_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int N_IN = 20;
  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    REG_SW   = 3'd0,
    REG_BTN  = 3'd1,
    REG_EVT  = 3'd2,
    REG_CNT  = 3'd3,
    REG_MASK = 3'd4
  } reg_e;

  logic [N_IN-1:0] meta, sync;
  logic [N_IN-1:0] hist_0, hist_1;
  logic [N_IN-1:0] deb, deb_nxt;
  logic [N_IN-1:0] stable_hi, stable_lo;
  logic [CW-1:0]   pre_cnt;
  logic            tick;
  logic [3:0]      btn_event, rise, evt_clr;
  logic [15:0]     evt_count, evt_nxt, cnt_base;
  logic [16:0]     cnt_sum;
  logic [2:0]      rise_cnt;
  logic            wr, cnt_clr;
  reg_e            sel;
  logic            unused_bits;

  assign unused_bits = ^{addr[31:5], addr[1:0], data_i[31:4]};

  // Raw pins are asynchronous to clk: two flops before anything else looks at them.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {btn, sw};
      sync <= meta;
    end
  end

  assign tick = (pre_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_cnt <= '0;
    else      pre_cnt <= tick ? '0 : pre_cnt + CW'(1);
  end

  assign wr      = ce & we;
  assign sel     = reg_e'(addr[4:2]);
  assign evt_clr = (wr && sel == REG_EVT) ? data_i[3:0] : 4'd0;
  assign cnt_clr = wr && (sel == REG_CNT);

  // The three-sample window is the sample taken on this tick plus the two stored ones,
  // so a debounced bit moves on the very tick that delivers the third agreeing sample.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    stable_hi = sync & hist_0 & hist_1;
    stable_lo = ~(sync | hist_0 | hist_1);
    deb_nxt   = deb;
    if (tick) deb_nxt = (deb | stable_hi) & ~stable_lo;
    rise      = deb_nxt[19:16] & ~deb[19:16];
    rise_cnt  = 3'd0;
    for (int i = 0; i < 4; i++) rise_cnt = rise_cnt + 3'(rise[i]);
    cnt_base  = cnt_clr ? 16'd0 : evt_count;
    cnt_sum   = {1'b0, cnt_base} + 17'(rise_cnt);
    evt_nxt   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // A new rise overrides a simultaneous W1C clear of the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_0    <= '0;
      hist_1    <= '0;
      deb       <= '0;
      btn_event <= '0;
      evt_count <= '0;
    end else begin
      if (tick) begin
        hist_1 <= hist_0;
        hist_0 <= sync;
      end
      deb       <= deb_nxt;
      btn_event <= (btn_event & ~evt_clr) | rise;
      evt_count <= evt_nxt;
    end
  end

`ifdef IO_IN_IRQ_EN
  logic [3:0] irq_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && sel == REG_MASK) irq_mask <= data_i[3:0];
      irq <= |(btn_event & irq_mask);
    end
  end
`endif

  always_comb begin
    data_o = '0;
    if (ce) begin
      case (sel)
        REG_SW:   data_o[15:0] = deb[15:0];
        REG_BTN:  data_o[3:0]  = deb[19:16];
        REG_EVT:  data_o[3:0]  = btn_event;
        REG_CNT:  data_o[15:0] = evt_count;
`ifdef IO_IN_IRQ_EN
        REG_MASK: data_o[3:0]  = irq_mask;
`endif
        default:  data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl with TICK_DIV=4; covers the irq path when IO_IN_IRQ_EN is defined.
module tb_io_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [15:0] sw = '0;
  logic [3:0]  btn = '0;
`ifdef IO_IN_IRQ_EN
  logic        irq;
  localparam logic [31:0] MASK_RB = 32'h0000_000F;
`else
  localparam logic [31:0] MASK_RB = 32'h0000_0000;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  off;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  io_input_ctrl #(.TICK_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .sw     (sw),
    .btn    (btn)
`ifdef IO_IN_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] val);
    ce   = 1'b1;
    we   = 1'b0;
    addr = {27'd0, off, 2'b00};
    #1;
    val  = data_o;
    ce   = 1'b0;
    addr = '0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check(name, v, exp);
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
    ce     = 1'b1;
    we     = 1'b1;
    addr   = {27'd0, off, 2'b00};
    data_i = d;
    @(posedge clk);
    #1;
    ce     = 1'b0;
    we     = 1'b0;
    addr   = '0;
    data_i = '0;
  endtask

  task automatic add_vec(input logic [2:0] off, input logic wr, input logic [31:0] wd,
                         input logic [31:0] exp);
    vec_t v;
    v.off   = off;
    v.wr    = wr;
    v.wdata = wd;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].off, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].off, v);
        check($sformatf("%s_vec%0d_off%0d", tag, i, vecs[i].off), v, vecs[i].exp);
        tick_n(1);
      end
    end
    vecs.delete();
  endtask

  initial begin
    // Power-on reset, then register file must read all zero.
    tick_n(3);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) add_vec(3'(i), 1'b0, 32'd0, 32'd0);
    run_vecs("reset");

    // Single button press: debounced within 2+12 clk, never faster than 2+2 ticks.
    btn = 4'b0001;
    tick_n(10);
    rd_chk("btn_early", 3'd1, 32'h0);
    tick_n(4);
    rd_chk("btn_state_press", 3'd1, 32'h1);
    tick_n(6);
    rd_chk("btn_event_press", 3'd2, 32'h1);
    rd_chk("evt_count_press", 3'd3, 32'h1);
    btn = 4'b0000;
    tick_n(16);
    rd_chk("btn_state_release", 3'd1, 32'h0);
    rd_chk("btn_event_release", 3'd2, 32'h1);
    rd_chk("evt_count_release", 3'd3, 32'h1);
    ce   = 1'b0;
    addr = 32'h8;
    #1;
    check("ce_low_reads_zero", data_o, 32'h0);
    addr = '0;
    tick_n(1);

    // Register map: read-only regs, undecoded offsets, W1C and clear-on-write.
    add_vec(3'd2, 1'b0, 32'd0,        32'h1);
    add_vec(3'd5, 1'b1, 32'hFFFFFFFF, 32'd0);
    add_vec(3'd5, 1'b0, 32'd0,        32'h0);
    add_vec(3'd0, 1'b1, 32'hFFFFFFFF, 32'd0);
    add_vec(3'd0, 1'b0, 32'd0,        32'h0);
    add_vec(3'd4, 1'b1, 32'hFFFFFFFF, 32'd0);
    add_vec(3'd4, 1'b0, 32'd0,        MASK_RB);
    add_vec(3'd4, 1'b1, 32'h0,        32'd0);
    add_vec(3'd2, 1'b1, 32'h0,        32'd0);
    add_vec(3'd2, 1'b0, 32'd0,        32'h1);
    add_vec(3'd3, 1'b1, 32'h0,        32'd0);
    add_vec(3'd3, 1'b0, 32'd0,        32'h0);
    add_vec(3'd2, 1'b1, 32'h1,        32'd0);
    add_vec(3'd2, 1'b0, 32'd0,        32'h0);
    add_vec(3'd7, 1'b0, 32'd0,        32'h0);
    run_vecs("regmap");

    // Short glitch on sw[3] must be filtered; a held pattern must pass.
    sw = 16'h0008;
    tick_n(5);
    sw = 16'h0000;
    tick_n(20);
    rd_chk("glitch_sw_state", 3'd0, 32'h0);
    rd_chk("glitch_no_event", 3'd2, 32'h0);
    sw = 16'h8001;
    tick_n(16);
    rd_chk("sw_state_held", 3'd0, 32'h8001);
    sw = 16'h0000;
    tick_n(16);
    rd_chk("sw_state_cleared", 3'd0, 32'h0);

    // All four buttons together, then saturation from near max.
    btn = 4'hF;
    tick_n(16);
    rd_chk("four_rise_count", 3'd3, 32'h4);
    rd_chk("four_rise_event", 3'd2, 32'hF);
    rd_chk("four_rise_state", 3'd1, 32'hF);
    btn = 4'h0;
    tick_n(16);
    force dut.evt_count = 16'hFFFE;
    tick_n(1);
    release dut.evt_count;
    tick_n(1);
    rd_chk("count_preset", 3'd3, 32'hFFFE);
    btn = 4'hF;
    tick_n(16);
    rd_chk("count_saturate", 3'd3, 32'hFFFF);
    btn = 4'h0;
    tick_n(16);

    // Reset mid-debounce; inputs held through release debounce at edge 12 exactly.
    sw  = 16'hA5A5;
    btn = 4'b0001;
    tick_n(6);
    rst = 1'b0;
    rd_chk("rst_sw", 3'd0, 32'h0);
    rd_chk("rst_btn", 3'd1, 32'h0);
    rd_chk("rst_event", 3'd2, 32'h0);
    rd_chk("rst_count", 3'd3, 32'h0);
    rd_chk("rst_mask", 3'd4, 32'h0);
    tick_n(2);
    rst = 1'b1;
    tick_n(11);
    rd_chk("post_rst_sw_early", 3'd0, 32'h0);
    bus_write(3'd2, 32'h1);
    rd_chk("post_rst_sw", 3'd0, 32'hA5A5);
    rd_chk("post_rst_btn", 3'd1, 32'h1);
    rd_chk("set_beats_w1c", 3'd2, 32'h1);
    rd_chk("held_through_rst_count", 3'd3, 32'h1);
    bus_write(3'd2, 32'h1);
    rd_chk("w1c_later", 3'd2, 32'h0);

    // Count clear coinciding with a new rise loads the number of new rises.
    btn = 4'b0000;
    rst = 1'b0;
    tick_n(1);
    btn = 4'b0001;
    rst = 1'b1;
    tick_n(12);
    rd_chk("clr_pre_count", 3'd3, 32'h1);
    btn = 4'b0011;
    tick_n(11);
    bus_write(3'd3, 32'h0);
    rd_chk("clr_with_rise_count", 3'd3, 32'h1);
    rd_chk("clr_with_rise_state", 3'd1, 32'h3);

`ifdef IO_IN_IRQ_EN
    // irq follows masked events one clk late and drops one clk after the W1C.
    btn = 4'b0000;
    rst = 1'b0;
    tick_n(1);
    btn = 4'b0010;
    rst = 1'b1;
    bus_write(3'd4, 32'h2);
    tick_n(10);
    check("irq_before_event", {31'd0, irq}, 32'h0);
    tick_n(1);
    rd_chk("irq_event_set", 3'd2, 32'h2);
    check("irq_lags_event", {31'd0, irq}, 32'h0);
    tick_n(1);
    check("irq_asserted", {31'd0, irq}, 32'h1);
    rd_chk("irq_mask_rb", 3'd4, 32'h2);
    bus_write(3'd2, 32'h2);
    check("irq_hold_at_clear", {31'd0, irq}, 32'h1);
    tick_n(1);
    check("irq_cleared", {31'd0, irq}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
